prio_sched: RTL and testbench

PRIO_SCHED -- requirements
Module: prio_sched

---
 rtl/prio_sched_if.sv | 31 +++
 rtl/prio_sched.sv | 134 +++++++++++++
 tb/tb_prio_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_sched_if.sv
// Bundle of queue-head inputs and scheduler outputs for prio_sched.
// The scheduler takes the master side; the queue/sink environment takes the slave side.
interface prio_sched_if #(
    parameter int fifo_data_width      = 256,
    parameter int fifo_num_of_priority = 8
);
    logic [fifo_num_of_priority-1:0]                 q_vld;
    logic [fifo_num_of_priority-1:0]                 q_sop;
    logic [fifo_num_of_priority-1:0]                 q_eop;
    logic [fifo_num_of_priority*fifo_data_width-1:0] q_data;
    logic [fifo_num_of_priority-1:0]                 q_read;
    logic                                            out_rdy;
    logic                                            sop;
    logic                                            eop;
    logic                                            vld;
    logic [fifo_data_width-1:0]                      out_data;
    logic [2:0]                                      cur_q;
    logic                                            busy;
    logic                                            err_pulse;
    logic [15:0]                                     pkt_cnt;

    modport master (
        input  q_vld, q_sop, q_eop, q_data, out_rdy,
        output q_read, sop, eop, vld, out_data, cur_q, busy, err_pulse, pkt_cnt
    );

    modport slave (
        output q_vld, q_sop, q_eop, q_data, out_rdy,
        input  q_read, sop, eop, vld, out_data, cur_q, busy, err_pulse, pkt_cnt
    );
endinterface

// File: rtl/prio_sched.sv
// Strict-priority packet scheduler over N FWFT queues: locks onto one queue per
// packet until eop, with a one-word registered output stage and protocol-error pulses.
module prio_sched #(
    parameter int fifo_data_width      = 256,
    parameter int fifo_num_of_priority = 8
) (
    input  logic         clk,
    input  logic         rst,
    prio_sched_if.master bus
);
    localparam int W = fifo_data_width;
    localparam int N = fifo_num_of_priority;

    typedef enum logic {IDLE, XFER} state_t;

    state_t         state_q, state_d;
    logic [2:0]     cur_q_q, cur_q_d;
    logic           vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
    logic [W-1:0]   data_q, data_d;
    logic [15:0]    cnt_q, cnt_d;

    logic [W-1:0]   head_data [N];
    logic [N-1:0]   sop_cand, junk, rd;
    logic [2:0]     sop_idx, junk_idx, pop_idx;
    logic           sop_any, junk_any, adv, fwd;

    for (genvar gi = 0; gi < N; gi++) begin : g_head
        assign head_data[gi] = bus.q_data[gi*W +: W];
    end

    assign sop_cand = bus.q_vld & bus.q_sop;
    assign junk     = bus.q_vld & ~bus.q_sop;
    assign adv      = !vld_q || bus.out_rdy;

    // Ascending scan: the last hit is the highest-priority queue.
    always_comb begin
        sop_any  = 1'b0;
        sop_idx  = '0;
        junk_any = 1'b0;
        junk_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sop_cand[i]) begin
                sop_any = 1'b1;
                sop_idx = 3'(i);
            end
            if (junk[i]) begin
                junk_any = 1'b1;
                junk_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_q_d = cur_q_q;
        vld_d   = vld_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        rd      = '0;
        fwd     = 1'b0;
        pop_idx = cur_q_q;

        case (state_q)
            IDLE: begin
                if (adv && sop_any) begin
                    fwd     = 1'b1;
                    pop_idx = sop_idx;
                    cur_q_d = sop_idx;
                    if (!bus.q_eop[sop_idx]) state_d = XFER;
                end else if (adv && junk_any) begin
                    // Headless fragment: drop it without touching the output stage.
                    rd[junk_idx] = 1'b1;
                    err_d        = 1'b1;
                end
            end
            XFER: begin
                if (adv && bus.q_vld[cur_q_q]) begin
                    fwd = 1'b1;
                    if (bus.q_eop[cur_q_q]) state_d = IDLE;
                    if (bus.q_sop[cur_q_q]) err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fwd) begin
            rd[pop_idx] = 1'b1;
            vld_d       = 1'b1;
            sop_d       = bus.q_sop[pop_idx];
            eop_d       = bus.q_eop[pop_idx];
            data_d      = head_data[pop_idx];
            if (bus.q_eop[pop_idx]) cnt_d = cnt_q + 16'd1;
        end else if (adv) begin
            vld_d = 1'b0;
            sop_d = 1'b0;
            eop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q_q <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q_q <= cur_q_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.q_read    = rst ? '0 : rd;
    assign bus.vld       = vld_q;
    assign bus.sop       = sop_q;
    assign bus.eop       = eop_q;
    assign bus.out_data  = data_q;
    assign bus.cur_q     = cur_q_q;
    assign bus.busy      = (state_q == XFER);
    assign bus.err_pulse = err_q;
    assign bus.pkt_cnt   = cnt_q;
endmodule

// File: tb/tb_prio_sched.sv
// Directed bench for prio_sched: queue-based packet model checked every cycle,
// plus literal expectations for the priority, atomicity, stall, error and reset scenarios.
module tb_prio_sched;
    localparam int W = 16;
    localparam int N = 8;

    typedef logic [W+1:0] word_t;   // {sop, eop, data}

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prio_sched_if #(.fifo_data_width(W), .fifo_num_of_priority(N)) bus();
    prio_sched #(.fifo_data_width(W), .fifo_num_of_priority(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    word_t        fifo [N][$];
    logic [W-1:0] obs [$];
    logic [N-1:0] pend = '0;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        word_t w;
        for (int i = 0; i < N; i++) begin
            if (fifo[i].size() > 0) begin
                w = fifo[i][0];
                bus.q_vld[i] = 1'b1;
                bus.q_sop[i] = w[W+1];
                bus.q_eop[i] = w[W];
                bus.q_data[i*W +: W] = w[W-1:0];
            end else begin
                bus.q_vld[i] = 1'b0;
                bus.q_sop[i] = 1'b0;
                bus.q_eop[i] = 1'b0;
                bus.q_data[i*W +: W] = '0;
            end
        end
    endtask

    task automatic push(input int q, input bit s, input bit e, input logic [W-1:0] d);
        fifo[q].push_back({s, e, d});
        refresh();
    endtask

    // Queue heads move one time unit after each edge, following the pops the model expected.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < N; i++)
                if (pend[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        refresh();
    endtask

    // Behavioural model: state is "which queue holds the lock" plus the expected output word.
    logic         m_vld, m_sop, m_eop, m_err;
    logic [W-1:0] m_data;
    logic [2:0]   m_cur;
    logic [15:0]  m_cnt;
    int           m_lock;

    always @(negedge clk) begin
        bit           adv, f, e;
        int           p;
        word_t        w;
        logic [N-1:0] exp_rd;
        if (rst) begin
            m_vld = 0; m_sop = 0; m_eop = 0; m_err = 0;
            m_data = '0; m_cur = '0; m_cnt = '0; m_lock = -1;
            pend = '0;
            chk("rst_q_read", 32'(bus.q_read), 32'd0);
            chk("rst_vld", 32'(bus.vld), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_cnt", 32'(bus.pkt_cnt), 32'd0);
            chk("rst_err", 32'(bus.err_pulse), 32'd0);
            chk("rst_data", 32'(bus.out_data), 32'd0);
        end else begin
            chk("vld", 32'(bus.vld), 32'(m_vld));
            chk("sop", 32'(bus.sop), 32'(m_sop));
            chk("eop", 32'(bus.eop), 32'(m_eop));
            chk("data", 32'(bus.out_data), 32'(m_data));
            chk("err_pulse", 32'(bus.err_pulse), 32'(m_err));
            chk("pkt_cnt", 32'(bus.pkt_cnt), 32'(m_cnt));
            chk("busy", 32'(bus.busy), 32'(m_lock >= 0));
            if (m_lock >= 0) chk("cur_q", 32'(bus.cur_q), 32'(m_cur));
            if (bus.vld && bus.out_rdy) obs.push_back(bus.out_data);

            adv = !m_vld || bus.out_rdy;
            p = -1; f = 0; e = 0;
            if (adv) begin
                if (m_lock < 0) begin
                    for (int i = 0; i < N; i++)
                        if (fifo[i].size() > 0) begin
                            w = fifo[i][0];
                            if (w[W+1]) p = i;
                        end
                    if (p >= 0) f = 1;
                    else begin
                        for (int i = 0; i < N; i++)
                            if (fifo[i].size() > 0) p = i;
                        e = (p >= 0);
                    end
                end else if (fifo[m_lock].size() > 0) begin
                    p = m_lock;
                    f = 1;
                    w = fifo[p][0];
                    e = w[W+1];
                end
            end
            exp_rd = '0;
            if (p >= 0) exp_rd[p] = 1'b1;
            chk("q_read", 32'(bus.q_read), 32'(exp_rd));
            pend = exp_rd;

            m_err = e;
            if (f) begin
                w = fifo[p][0];
                m_vld = 1; m_sop = w[W+1]; m_eop = w[W]; m_data = w[W-1:0];
                if (m_lock < 0) begin
                    m_cur  = 3'(p);
                    m_lock = w[W] ? -1 : p;
                end else if (w[W]) m_lock = -1;
                if (w[W]) m_cnt = m_cnt + 16'd1;
            end else if (adv) begin
                m_vld = 0; m_sop = 0; m_eop = 0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_obs(input string name, input logic [W-1:0] exp [$]);
        chk({name, "_len"}, 32'(obs.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++)
            chk(name, 32'(k < obs.size() ? obs[k] : 'x), 32'(exp[k]));
    endtask

    initial begin
        logic [W-1:0] hold;
        rst = 1'b1;
        bus.out_rdy = 1'b1;
        refresh();
        repeat (2) step();
        rst = 1'b0;

        // Two single-word packets arriving together: higher index first.
        obs.delete();
        push(2, 1, 1, 16'h0022);
        push(5, 1, 1, 16'h0055);
        repeat (4) step();
        chk_obs("prio_order", '{16'h0055, 16'h0022});
        chk("prio_cnt", 32'(bus.pkt_cnt), 32'd2);

        // Higher-priority sop must wait for the locked packet's eop.
        obs.delete();
        for (int k = 0; k < 4; k++) push(1, k == 0, k == 3, 16'h0011 + 16'(k));
        repeat (2) step();
        push(7, 1, 1, 16'h0077);
        repeat (6) step();
        chk_obs("atomic", '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0077});
        chk("atomic_cnt", 32'(bus.pkt_cnt), 32'd4);

        // Downstream stall mid-packet.
        obs.delete();
        for (int k = 0; k < 4; k++) push(4, k == 0, k == 3, 16'h0041 + 16'(k));
        repeat (2) step();
        bus.out_rdy = 1'b0;
        hold = bus.out_data;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_data", 32'(bus.out_data), 32'(hold));
            chk("stall_vld", 32'(bus.vld), 32'd1);
            chk("stall_rd", 32'(bus.q_read), 32'd0);
        end
        bus.out_rdy = 1'b1;
        repeat (6) step();
        chk_obs("stall", '{16'h0041, 16'h0042, 16'h0043, 16'h0044});

        // Repeated sop inside a packet is forwarded and flagged.
        obs.delete();
        push(2, 1, 0, 16'h00A1);
        push(2, 1, 0, 16'h00A2);
        push(2, 0, 1, 16'h00A3);
        repeat (2) step();
        chk("dup_sop_err", 32'(bus.err_pulse), 32'd1);
        chk("dup_sop_sop", 32'(bus.sop), 32'd1);
        chk("dup_sop_busy", 32'(bus.busy), 32'd1);
        repeat (3) step();
        chk_obs("dup_sop", '{16'h00A1, 16'h00A2, 16'h00A3});

        // Headless word in IDLE is discarded.
        obs.delete();
        push(3, 0, 0, 16'h0033);
        step();
        chk("junk_err", 32'(bus.err_pulse), 32'd1);
        chk("junk_vld", 32'(bus.vld), 32'd0);
        chk("junk_popped", 32'(fifo[3].size()), 32'd0);
        step();
        chk("junk_err_once", 32'(bus.err_pulse), 32'd0);
        chk("junk_obs", 32'(obs.size()), 32'd0);

        // Asynchronous reset mid-packet.
        push(6, 1, 0, 16'h0061);
        push(6, 0, 0, 16'h0062);
        push(6, 0, 0, 16'h0063);
        repeat (2) step();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 32'(bus.vld), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_cnt", 32'(bus.pkt_cnt), 32'd0);
        chk("arst_rd", 32'(bus.q_read), 32'd0);
        repeat (2) step();
        rst = 1'b0;

        // Counter wrap: 0xFFFF packets, then one more.
        for (int k = 0; k < 65535; k++) fifo[0].push_back({1'b1, 1'b1, 16'(k)});
        refresh();
        for (int n = 0; n < 70000 && fifo[0].size() > 0; n++) step();
        repeat (2) step();
        chk("wrap_drain", 32'(fifo[0].size()), 32'd0);
        chk("cnt_ffff", 32'(bus.pkt_cnt), 32'h0000_FFFF);
        push(0, 1, 1, 16'hBEEF);
        repeat (3) step();
        chk("cnt_wrap", 32'(bus.pkt_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
